// File: rtl/alarm_audio_pkg.sv
// Shared encodings for the alarm audio path.
//   mode_e   : operating mode carried on the 2-bit 'mode' input
//   FMT_*    : serial frame format selector for the I2S transmitter
package alarm_audio_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_CONT  = 2'd1,
      MODE_PULSE = 2'd2,
      MODE_TEST  = 2'd3
   } mode_e;

   localparam int FMT_I2S = 0;   // MSB one bit clock after the LRCK edge
   localparam int FMT_LJ  = 1;   // MSB on the same bit clock as the LRCK edge

endpackage

// File: rtl/i2s_tx_serializer.sv
// Stereo PCM transmitter: divides CLK into MCLK and BCLK, walks bit_idx over
// a 2*SAMPLE_W-bit frame and shifts out the same word in both slots.
// Ports:
//   CLK, RST      system clock, synchronous active-low reset
//   sample        word loaded into left and right slots at each frame start
//   frame_tick    combinational, high on the CLK edge that starts a frame
//                 (the parent updates its state on this same edge)
//   frame_strobe  registered one-cycle pulse, visible with the first bit
//   mclk, bclk, lrck, sdata  codec-facing serial interface
module i2s_tx_serializer
   import alarm_audio_pkg::*;
#(
   parameter int SAMPLE_W  = 16,
   parameter int MCLK_HALF = 2,
   parameter int BCLK_HALF = 4,
   parameter int FORMAT    = FMT_I2S
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [SAMPLE_W-1:0] sample,
   output logic                frame_tick,
   output logic                frame_strobe,
   output logic                mclk,
   output logic                bclk,
   output logic                lrck,
   output logic                sdata
);

   localparam int FRAME_BITS = 2 * SAMPLE_W;
   localparam int IDX_W      = $clog2(FRAME_BITS);
   localparam int MC_W       = $clog2(MCLK_HALF + 1);
   localparam int BC_W       = $clog2(BCLK_HALF + 1);

   logic [MC_W-1:0]       mclk_cnt;
   logic [BC_W-1:0]       bclk_cnt;
   logic [IDX_W-1:0]      bit_idx;
   logic [IDX_W-1:0]      idx_next;
   logic [FRAME_BITS-1:0] shreg;
   logic [FRAME_BITS-1:0] shreg_next;
   logic                  fall;

   // BCLK is about to go 1->0 on this edge; everything serial moves here.
   assign fall       = bclk && (bclk_cnt == BC_W'(BCLK_HALF - 1));
   assign idx_next   = (bit_idx == IDX_W'(FRAME_BITS - 1)) ? '0 : bit_idx + IDX_W'(1);
   assign frame_tick = fall && (bit_idx == IDX_W'(FRAME_BITS - 1));
   assign shreg_next = frame_tick ? {sample, sample} : {shreg[FRAME_BITS-2:0], 1'b0};

   always_ff @(posedge CLK) begin
      if (!RST) begin
         mclk_cnt     <= '0;
         bclk_cnt     <= '0;
         mclk         <= 1'b0;
         bclk         <= 1'b0;
         bit_idx      <= '0;
         shreg        <= '0;
         lrck         <= 1'b0;
         sdata        <= 1'b0;
         frame_strobe <= 1'b0;
      end else begin
         if (mclk_cnt == MC_W'(MCLK_HALF - 1)) begin
            mclk_cnt <= '0;
            mclk     <= ~mclk;
         end else begin
            mclk_cnt <= mclk_cnt + MC_W'(1);
         end
         if (bclk_cnt == BC_W'(BCLK_HALF - 1)) begin
            bclk_cnt <= '0;
            bclk     <= ~bclk;
         end else begin
            bclk_cnt <= bclk_cnt + BC_W'(1);
         end
         frame_strobe <= frame_tick;
         if (fall) begin
            bit_idx <= idx_next;
            shreg   <= shreg_next;
            lrck    <= (idx_next >= IDX_W'(SAMPLE_W));
            // Left-justified sends the fresh MSB; I2S repeats the previous
            // bit position, which delays the whole stream by one bit clock
            // and puts the right-slot LSB into bit 0 of the next frame.
            sdata   <= (FORMAT == FMT_LJ) ? shreg_next[FRAME_BITS-1] : shreg[FRAME_BITS-1];
         end
      end
   end

endmodule

// File: rtl/alarm_tone_i2s.sv
// Alarm audio source: maps Distance to a square-wave pitch, optionally gates
// it into beeps, and streams it as stereo PCM through i2s_tx_serializer.
// Ports:
//   CLK, RST      system clock, synchronous active-low reset
//   Distance      ultrasonic distance, sampled once per frame
//   mode          0 off, 1 continuous, 2 pulsed, 3 test tone
//   armed         alarm enable
//   MCLK, BCLK, LRCK, SDATA   codec clocks and serial data
//   alarm_active  alarm state of the frame currently being sent
//   frame_strobe  one-cycle pulse at each frame start
module alarm_tone_i2s
   import alarm_audio_pkg::*;
#(
   parameter int DIST_W     = 8,
   parameter int SAMPLE_W   = 16,
   parameter int THRESH     = 100,
   parameter int AMP        = 16'h2000,
   parameter int MCLK_HALF  = 2,
   parameter int BCLK_HALF  = 4,
   parameter int TONE_BASE  = 4,
   parameter int TONE_SHIFT = 3,
   parameter int BEEP_ON    = 8,
   parameter int BEEP_SCALE = 1,
   parameter int FORMAT     = FMT_I2S
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DIST_W-1:0] Distance,
   input  logic [1:0]        mode,
   input  logic              armed,
   output logic              MCLK,
   output logic              BCLK,
   output logic              LRCK,
   output logic              SDATA,
   output logic              alarm_active,
   output logic              frame_strobe
);

   // Counter widths cover the largest half-period and beep period that an
   // all-ones distance can produce.
   localparam int H_W = DIST_W + $clog2(TONE_BASE + 1);
   localparam int B_W = DIST_W + $clog2(BEEP_SCALE + 1) + $clog2(BEEP_ON + 1);
   localparam logic [SAMPLE_W-1:0] AMP_POS = SAMPLE_W'(AMP);
   localparam logic [SAMPLE_W-1:0] AMP_NEG = SAMPLE_W'(-AMP);

   logic [DIST_W-1:0]   dist_l;
   mode_e               mode_l;
   logic                armed_l;
   logic [H_W-1:0]      tone_cnt;
   logic [B_W-1:0]      beep_cnt;
   logic                phase;
   logic                frame_tick;

   mode_e               mode_in;
   logic                restart;
   logic                active_n;
   logic                tone_on;
   logic [H_W-1:0]      half;
   logic [B_W-1:0]      off_len;
   logic [B_W-1:0]      beep_last;
   logic [H_W-1:0]      tone_c;
   logic [B_W-1:0]      beep_c;
   logic                phase_c;
   logic [H_W-1:0]      tone_n;
   logic [B_W-1:0]      beep_n;
   logic                phase_n;
   logic [SAMPLE_W-1:0] sample_n;

   // Next-frame state. It is evaluated from the live inputs because it is
   // only committed on frame_tick, which is exactly when Distance, mode and
   // armed are latched; the word produced here is the one that frame carries.
   always_comb begin
      mode_in   = mode_e'(mode);
      restart   = (mode_in != mode_l);
      active_n  = (mode_in == MODE_TEST) || (armed && (int'(Distance) < THRESH));
      if (mode_in == MODE_TEST) begin
         half = H_W'(TONE_BASE);
      end else begin
         half = H_W'(TONE_BASE) + H_W'(Distance >> TONE_SHIFT);
      end
      off_len   = B_W'(Distance) * B_W'(BEEP_SCALE);
      beep_last = B_W'(BEEP_ON) + off_len - B_W'(1);

      // A mode change starts the new mode from a clean positive half-cycle.
      tone_c  = restart ? '0 : tone_cnt;
      beep_c  = restart ? '0 : beep_cnt;
      phase_c = restart ? 1'b1 : phase;

      tone_on  = 1'b0;
      tone_n   = '0;
      beep_n   = '0;
      phase_n  = 1'b1;
      sample_n = '0;

      if (active_n) begin
         case (mode_in)
            MODE_CONT, MODE_TEST: tone_on = 1'b1;
            MODE_PULSE: begin
               tone_on = (beep_c < B_W'(BEEP_ON));
               // >= rather than == so a shrinking off-time cannot strand
               // the counter past the end of the period.
               beep_n  = (beep_c >= beep_last) ? '0 : beep_c + B_W'(1);
            end
            default: tone_on = 1'b0;
         endcase
      end

      // Outside a tone window the tone counter and phase stay parked, so
      // every beep burst begins on a positive half-cycle.
      if (tone_on) begin
         sample_n = phase_c ? AMP_POS : AMP_NEG;
         if (tone_c >= half - H_W'(1)) begin
            tone_n  = '0;
            phase_n = ~phase_c;
         end else begin
            tone_n  = tone_c + H_W'(1);
            phase_n = phase_c;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         dist_l   <= '1;
         mode_l   <= MODE_OFF;
         armed_l  <= 1'b0;
         tone_cnt <= '0;
         beep_cnt <= '0;
         phase    <= 1'b1;
      end else if (frame_tick) begin
         dist_l   <= Distance;
         mode_l   <= mode_in;
         armed_l  <= armed;
         tone_cnt <= tone_n;
         beep_cnt <= beep_n;
         phase    <= phase_n;
      end
   end

   assign alarm_active = (mode_l == MODE_TEST) || (armed_l && (int'(dist_l) < THRESH));

   i2s_tx_serializer #(
      .SAMPLE_W  (SAMPLE_W),
      .MCLK_HALF (MCLK_HALF),
      .BCLK_HALF (BCLK_HALF),
      .FORMAT    (FORMAT)
   ) u_ser (
      .CLK          (CLK),
      .RST          (RST),
      .sample       (sample_n),
      .frame_tick   (frame_tick),
      .frame_strobe (frame_strobe),
      .mclk         (MCLK),
      .bclk         (BCLK),
      .lrck         (LRCK),
      .sdata        (SDATA)
   );

endmodule

// File: tb/tb_alarm_tone_i2s.sv
// Directed bench for alarm_tone_i2s. Two instances (I2S and left-justified)
// share the stimulus; a monitor rebuilds each frame into {left, right}.
module tb_alarm_tone_i2s;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] distance;
   logic [1:0] mode;
   logic       armed;

   logic mclk_a, bclk_a, lrck_a, sdata_a, active_a, strobe_a;
   logic mclk_b, bclk_b, lrck_b, sdata_b, active_b, strobe_b;

   logic [31:0] i2s_q[$];
   logic [31:0] lj_q[$];
   logic [31:0] lr_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] sr_a, sr_b, lr_sr;
   logic        bclk_d = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   alarm_tone_i2s #(.FORMAT(0)) dut_i2s (
      .CLK(CLK), .RST(RST), .Distance(distance), .mode(mode), .armed(armed),
      .MCLK(mclk_a), .BCLK(bclk_a), .LRCK(lrck_a), .SDATA(sdata_a),
      .alarm_active(active_a), .frame_strobe(strobe_a)
   );

   alarm_tone_i2s #(.FORMAT(1)) dut_lj (
      .CLK(CLK), .RST(RST), .Distance(distance), .mode(mode), .armed(armed),
      .MCLK(mclk_b), .BCLK(bclk_b), .LRCK(lrck_b), .SDATA(sdata_b),
      .alarm_active(active_b), .frame_strobe(strobe_b)
   );

   // ---------------- frame monitor ----------------
   // I2S: the frame is complete once bit 0 of the next frame has arrived.
   // LJ and LRCK: the frame is complete before that bit is shifted in.
   always @(negedge CLK) begin
      if (!RST) begin
         sr_a  = '0;
         sr_b  = '0;
         lr_sr = '0;
         i2s_q.delete();
         lj_q.delete();
         lr_q.delete();
      end else if (bclk_d && !bclk_a) begin
         if (strobe_a) begin
            i2s_q.push_back({sr_a[30:0], sdata_a});
            lj_q.push_back(sr_b);
            lr_q.push_back(lr_sr);
         end
         sr_a  = {sr_a[30:0], sdata_a};
         sr_b  = {sr_b[30:0], sdata_b};
         lr_sr = {lr_sr[30:0], lrck_b};
      end
      bclk_d = bclk_a;
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sq(input int k, input int h);
      return (((k - 1) / h) % 2 == 0) ? 16'h2000 : 16'hE000;
   endfunction

   function automatic logic pick(input int sel);
      case (sel)
         0:       return mclk_a;
         1:       return bclk_a;
         default: return lrck_a;
      endcase
   endfunction

   task automatic compare_frames(input string tag);
      logic [31:0] got;
      for (int k = 0; k < exp_q.size(); k++) begin
         got = 'x;
         if (k + 1 < i2s_q.size()) got = i2s_q[k+1];
         check($sformatf("%s_i2s_f%0d", tag, k + 1), got, exp_q[k]);
         got = 'x;
         if (k + 1 < lj_q.size()) got = lj_q[k+1];
         check($sformatf("%s_lj_f%0d", tag, k + 1), got, exp_q[k]);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset(input logic [7:0] d, input logic [1:0] m, input logic a);
      distance = d;
      mode     = m;
      armed    = a;
      RST      = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic wait_q(input int n);
      for (int t = 0; t < (n + 2) * 260; t++) begin
         if (i2s_q.size() >= n && lj_q.size() >= n) break;
         @(negedge CLK);
      end
      check("frames_seen", 32'(i2s_q.size() >= n && lj_q.size() >= n), 32'd1);
   endtask

   task automatic wait_strobes(input int n);
      int seen;
      seen = 0;
      for (int t = 0; t < n * 256 + 600 && seen < n; t++) begin
         @(negedge CLK);
         if (strobe_a) seen++;
      end
      check("strobes_seen", seen, n);
   endtask

   task automatic wait_falls(input int n);
      int   seen;
      logic p;
      seen = 0;
      p    = bclk_a;
      for (int t = 0; t < n * 8 + 40 && seen < n; t++) begin
         @(negedge CLK);
         if (p && !bclk_a) seen++;
         p = bclk_a;
      end
      check("falls_seen", seen, n);
   endtask

   task automatic measure(input int sel, output int period);
      logic p, c;
      int   first;
      first  = -1;
      period = 0;
      p      = pick(sel);
      for (int n = 0; n < 1200; n++) begin
         @(negedge CLK);
         c = pick(sel);
         if (!p && c) begin
            if (first < 0) first = n;
            else begin
               period = n - first;
               break;
            end
         end
         p = c;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      RST      = 1'b0;
      distance = 8'd200;
      mode     = 2'd1;
      armed    = 1'b1;
      repeat (3) @(negedge CLK);
      check("reset_outputs", 32'({mclk_a, bclk_a, lrck_a, sdata_a, active_a, strobe_a,
                                 mclk_b, bclk_b, lrck_b, sdata_b, active_b, strobe_b}), 32'd0);
      RST = 1'b1;

      // Far target: clock periods and silent frames.
      measure(0, cyc); check("mclk_period", cyc, 4);
      measure(1, cyc); check("bclk_period", cyc, 8);
      measure(2, cyc); check("lrck_period", cyc, 256);
      wait_q(4);
      check("idle_frame0", i2s_q[0], 32'd0);
      exp_q.delete();
      for (int k = 1; k <= 3; k++) exp_q.push_back(32'd0);
      compare_frames("far");
      check("alarm_far", 32'(active_a), 32'd0);

      // Continuous tone, Distance 50 -> H = 10 frames.
      do_reset(8'd50, 2'd1, 1'b1);
      wait_q(25);
      exp_q.delete();
      for (int k = 1; k <= 24; k++) exp_q.push_back({sq(k, 10), sq(k, 10)});
      compare_frames("cont");
      check("alarm_cont", 32'(active_a), 32'd1);
      check("lrck_pattern", lr_q[1], 32'h0000FFFF);

      // Pulsed, Distance 10 -> 8 tone frames (H = 5) then 10 silent frames.
      do_reset(8'd10, 2'd2, 1'b1);
      wait_q(37);
      exp_q.delete();
      for (int k = 1; k <= 36; k++) begin
         int p;
         p = (k - 1) % 18;
         exp_q.push_back((p < 8) ? {sq(p + 1, 5), sq(p + 1, 5)} : 32'd0);
      end
      compare_frames("pulse");
      check("alarm_pulse", 32'(active_a), 32'd1);

      // Test tone ignores armed and Distance: H = TONE_BASE = 4.
      do_reset(8'd200, 2'd3, 1'b0);
      wait_q(11);
      exp_q.delete();
      for (int k = 1; k <= 10; k++) exp_q.push_back({sq(k, 4), sq(k, 4)});
      compare_frames("test");
      check("alarm_test", 32'(active_a), 32'd1);

      // Mode off with a near target: alarm is active, output silent.
      do_reset(8'd50, 2'd0, 1'b1);
      wait_q(4);
      exp_q.delete();
      for (int k = 1; k <= 3; k++) exp_q.push_back(32'd0);
      compare_frames("off");
      check("alarm_off_mode", 32'(active_a), 32'd1);

      // Distance 50 -> 20 in the middle of frame 3; H becomes 6 from frame 4.
      // Tone count is 3 entering frame 4, so the flip lands after frame 6.
      do_reset(8'd50, 2'd1, 1'b1);
      wait_strobes(3);
      repeat (128) @(negedge CLK);
      distance = 8'd20;
      wait_q(21);
      exp_q.delete();
      for (int k = 1; k <= 20; k++) begin
         logic [15:0] w;
         if (k <= 6) w = 16'h2000;
         else w = (((k - 7) / 6) % 2 == 0) ? 16'hE000 : 16'h2000;
         exp_q.push_back({w, w});
      end
      compare_frames("dchg");

      // Reset while bit_idx = 13, then a clean restart.
      wait_strobes(1);
      wait_falls(13);
      RST = 1'b0;
      @(negedge CLK);
      check("midframe_reset_outputs", 32'({mclk_a, bclk_a, lrck_a, sdata_a, active_a, strobe_a,
                                          mclk_b, bclk_b, lrck_b, sdata_b, active_b, strobe_b}), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      cyc = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge CLK);
         cyc++;
         if (strobe_a) break;
      end
      check("restart_latency", cyc, 256);
      wait_q(2);
      exp_q.delete();
      exp_q.push_back(32'h2000_2000);
      compare_frames("restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
